// File: rtl/regfile_write_scoreboard.sv
// rtl/regfile_write_scoreboard.sv - writeback enable decoder and busy-bit hazard scoreboard
module regfile_write_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic                iss_wr,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic [ADDR_W-1:0]   iss_rs1,
  input  logic [ADDR_W-1:0]   iss_rs2,
  output logic                stall,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  output logic [NUM_REGS-1:0] WriteEnable,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_count,
  output logic                wb_err
);

  localparam int FullRegs = 2**ADDR_W;
  localparam logic [ADDR_W:0] ZeroIdx = (ADDR_W+1)'(ZERO_REG);
  localparam logic [ADDR_W:0] NumRegsIdx = (ADDR_W+1)'(NUM_REGS);

  // Padded to the full address space so any index is safe; out-of-range slots read as idle.
  logic [FullRegs-1:0] busyFull;
  logic [FullRegs-1:0] effBusy;
  logic [NUM_REGS-1:0] busyNext;
  logic [ADDR_W:0]     countNext;
  logic                issueFire;
  logic                wbInRange;
  logic                errNext;

  always_comb begin
    busyFull = '0;
    effBusy  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busyFull[i] = busy[i];
      effBusy[i]  = busy[i] && !((BYPASS != 0) && wb_valid && wb_rd == ADDR_W'(i));
    end
  end

  always_comb begin
    WriteEnable = '0;
    for (int i = 0; i < NUM_REGS; i++)
      WriteEnable[i] = wb_valid && wb_rd == ADDR_W'(i) && i != ZERO_REG;
  end

  assign stall = iss_valid && (effBusy[iss_rs1] || effBusy[iss_rs2] ||
                               (iss_wr && effBusy[iss_rd]));
  assign issueFire = iss_valid && !stall && !flush;

  // A new issue claiming a register outranks the retiring writeback to it.
  always_comb begin
    busyNext = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r == ZERO_REG || flush)
        busyNext[r] = 1'b0;
      else if (issueFire && iss_wr && iss_rd == ADDR_W'(r))
        busyNext[r] = 1'b1;
      else if (wb_valid && wb_rd == ADDR_W'(r))
        busyNext[r] = 1'b0;
      else
        busyNext[r] = busy[r];
    end
  end

  always_comb begin
    countNext = '0;
    for (int r = 0; r < NUM_REGS; r++)
      countNext = countNext + (ADDR_W+1)'(busyNext[r]);
  end

  assign wbInRange = {1'b0, wb_rd} != ZeroIdx && {1'b0, wb_rd} < NumRegsIdx;
  assign errNext   = wb_valid && wbInRange && !busyFull[wb_rd] && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= '0;
      busy_count <= '0;
      wb_err     <= 1'b0;
    end else begin
      busy       <= busyNext;
      busy_count <= countNext;
      if (errNext)
        wb_err <= 1'b1;
    end
  end

endmodule
